led_seg_display: RTL
====================

Name: led_seg_display

Overview:
- Downstream consumer of the 8-bit LED up/down counter value.
- Converts the binary count to three decimal digits with a sequential double-dabble converter.
- Time-multiplexes the digits onto a 4-digit common-anode 7-segment display; the leftmost digit shows the count direction ('U' or 'd').
- Runs on the board clock, not the divided counter clock.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit stays lit; must be >= 2; sim uses 4.
- CW, 16: refresh counter width; must satisfy 2^CW > REFRESH_DIV.

Ports:
- clk  in  1  board clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- value  in  8  binary count from the counter; may change asynchronously to conversion.
- ud  in  1  direction: 1 = up ('U'), 0 = down ('d').
- an  out  4  digit anodes, active-low, one-hot-low; an[0] = ones.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; tied 1.
- busy  out  1  high while a conversion is in progress.

Behaviour:
- Reset (reset==0 at a clk edge):
  - an=4'b1111, seg=7'b1111111, dp=1, busy=0.
  - BCD display regs = 0, scan index = 0, refresh count = 0, FSM = IDLE.
  - force flag set, so the first conversion after reset starts unconditionally.
  - Reset mid-conversion aborts it; the old result is discarded.
- Conversion FSM, states IDLE, SHIFT, LATCH:
  - IDLE: if force, or value != last_conv, then capture value into an 8-bit shift reg, clear the 12-bit BCD accumulator, cnt=0, busy<=1, clear force, go to SHIFT.
  - SHIFT (exactly 8 cycles): first add 3 to each BCD nibble >= 5, then shift {bcd,shift} left by 1; cnt++; leave after cnt==7.
  - LATCH: copy BCD to hundreds/tens/ones display regs; last_conv <= captured value; busy<=0; go to IDLE.
  - Latency: value change to updated display regs = 10 clk (1 capture + 8 shift + 1 latch).
  - Value changes during SHIFT/LATCH are ignored; they are re-detected in the next IDLE cycle.
  - Range: hundreds 0..2, tens 0..9, ones 0..9.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1.
  - At terminal count: counter -> 0 and scan index increments mod 4 (3 -> 0 wrap).
- Index to anode/content:
  - 0: an=1110, ones.
  - 1: an=1101, tens.
  - 2: an=1011, hundreds.
  - 3: an=0111, ud glyph.
- Outputs an/seg are registered and reflect the new index one clk after the index changes.
- Leading-zero blanking:
  - hundreds blank when 0.
  - tens blank when hundreds==0 and tens==0.
  - ones never blank.
- Glyphs:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - U=1000001, d=0100001, blank=1111111.
- ud is sampled every cycle while index 3 is displayed; no conversion is needed for it.
- Display regs are stable during conversion, so the old value stays shown until LATCH (no glitching).

Decomposition:
- Package led_disp_pkg holds:
  - the segment glyph constants (SEG_0..SEG_9, SEG_U, SEG_D, SEG_BLANK);
  - the FSM state enum (IDLE, SHIFT, LATCH);
  - the anode one-hot constants.
- One sub-module, bin2bcd_seq: the sequential 8-bit double-dabble converter.
  - Ports: clk, reset, start, bin[7:0], busy, done, bcd[11:0].
  - The top keeps the change detection, force flag, scanning, blanking and glyph decode.

Test Plan (REFRESH_DIV=4):
- Reset held 3 clk, value=0, ud=1 -> during reset an=1111, seg=1111111, busy=0. After release: busy high for clk 1..9, ones digit shows 1000000 on an=1110, an=1101 and an=1011 show 1111111, an=0111 shows 1000001.
- value=8'd255 steady -> 10 clk after change the scan shows 0010010 (5) on an=1110, 0010010 on an=1101, 0100100 (2) on an=1011.
- value=8'd7, ud=0 -> tens and hundreds blank (1111111), ones=1111000, an=0111 shows 0100001.
- value 8'd100 -> 8'd42 applied 3 clk into a conversion -> first latch shows 1,0,0 (hundreds,tens,ones). busy then reasserts within 1 clk, and 10 clk later the display shows blank,4,2.
- Scan wrap: monitor 20 clk of an -> sequence 1110,1101,1011,0111,1110, each held 4 clk, exactly one anode low at all times after reset.
- reset asserted on the 4th SHIFT cycle of converting 8'd200 -> outputs return to reset values next clk. After release a forced conversion shows 2,0,0 after 10 clk, and no partial BCD is ever displayed.

Source files
------------

// File: rtl/led_disp_pkg.sv
// Shared constants for the LED counter display: segment glyphs, anode
// one-hot patterns and the conversion FSM state type.
package led_disp_pkg;

  // Segment glyphs, {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Anode patterns, active-low; an[0] drives the ones digit.
  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_HUND = 4'b1011;
  localparam logic [3:0] AN_DIR  = 4'b0111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} conv_state_t;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    digit_glyph = SEG_0;
      4'd1:    digit_glyph = SEG_1;
      4'd2:    digit_glyph = SEG_2;
      4'd3:    digit_glyph = SEG_3;
      4'd4:    digit_glyph = SEG_4;
      4'd5:    digit_glyph = SEG_5;
      4'd6:    digit_glyph = SEG_6;
      4'd7:    digit_glyph = SEG_7;
      4'd8:    digit_glyph = SEG_8;
      4'd9:    digit_glyph = SEG_9;
      default: digit_glyph = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit double-dabble converter: one capture cycle, eight
// add-3/shift cycles, one latch cycle during which done is high.
module bin2bcd_seq
  import led_disp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_t state_q, state_d;
  logic [7:0]  shift_q;
  logic [11:0] bcd_q;
  logic [11:0] bcd_adj;
  logic [2:0]  cnt_q;
  logic        busy_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == 3'd7) state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          shift_q <= bin;
          bcd_q   <= '0;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
        SHIFT: begin
          {bcd_q, shift_q} <= {bcd_adj[10:0], shift_q, 1'b0};
          cnt_q            <= cnt_q + 3'd1;
        end
        LATCH:   busy_q <= 1'b0;
        default: busy_q <= 1'b0;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = (state_q == LATCH);
  assign bcd  = bcd_q;

endmodule

// File: rtl/led_seg_display.sv
// Converts the 8-bit counter value to decimal and time-multiplexes it, plus
// a direction glyph, onto a 4-digit common-anode 7-segment display.
module led_seg_display
  import led_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int CW          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       ud,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  logic          force_q;
  logic [7:0]    last_conv_q;
  logic [7:0]    cap_q;
  logic [3:0]    hund_q, tens_q, ones_q;
  logic [CW-1:0] refresh_q;
  logic [1:0]    idx_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          conv_busy;
  logic          conv_done;
  logic [11:0]   conv_bcd;
  logic          start;

  // The converter's busy covers SHIFT and LATCH, so !busy means it is idle.
  assign start = !conv_busy && (force_q || (value != last_conv_q));

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      force_q     <= 1'b1;
      last_conv_q <= '0;
      cap_q       <= '0;
      hund_q      <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
    end else begin
      if (start) begin
        cap_q   <= value;
        force_q <= 1'b0;
      end
      if (conv_done) begin
        hund_q      <= conv_bcd[11:8];
        tens_q      <= conv_bcd[7:4];
        ones_q      <= conv_bcd[3:0];
        last_conv_q <= cap_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      refresh_q <= '0;
      idx_q     <= '0;
    end else if (refresh_q == CW'(REFRESH_DIV - 1)) begin
      refresh_q <= '0;
      idx_q     <= idx_q + 2'd1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    case (idx_q)
      2'd0: begin
        an_d  = AN_ONES;
        seg_d = digit_glyph(ones_q);
      end
      2'd1: begin
        an_d  = AN_TENS;
        seg_d = (hund_q == 4'd0 && tens_q == 4'd0) ? SEG_BLANK : digit_glyph(tens_q);
      end
      2'd2: begin
        an_d  = AN_HUND;
        seg_d = (hund_q == 4'd0) ? SEG_BLANK : digit_glyph(hund_q);
      end
      default: begin
        an_d  = AN_DIR;
        seg_d = ud ? SEG_U : SEG_D;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;
  assign busy = conv_busy;

endmodule
